// File: rtl/mem_arbiter_if.sv
// Bundle between the memory arbiter, the IF/MEM pipeline stages and the unified memory.
// The master side is the arbiter; the slave side is the pipeline plus memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_flush;
   logic [DATA_W-1:0] i_rdata;
   logic              i_valid;
   logic              i_stall;

   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              d_stall;

   logic              hlt;

   logic              m_en;
   logic              m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   modport master (
      input  i_req, i_addr, i_flush, d_req, d_wr, d_addr, d_wdata, hlt, m_rdata,
      output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
             m_en, m_wr, m_addr, m_wdata
   );

   modport slave (
      output i_req, i_addr, i_flush, d_req, d_wr, d_addr, d_wdata, hlt, m_rdata,
      input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
             m_en, m_wr, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the 5-stage pipeline: data has fixed priority
// over fetch, each access runs LAT cycles followed by a one-cycle response.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int LAT    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);
   localparam int CNT_W = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              kill_q, kill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         kill_q    <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         kill_q    <= kill_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      kill_d    = kill_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (bus.d_req) begin
               owner_d = 1'b1;
               addr_d  = bus.d_addr;
               wr_d    = bus.d_wr;
               wdata_d = bus.d_wdata;
               cnt_d   = CNT_W'(LAT - 1);
               state_d = BUSY;
            end else if (bus.i_req && !bus.hlt) begin
               owner_d = 1'b0;
               addr_d  = bus.i_addr;
               wr_d    = 1'b0;
               cnt_d   = CNT_W'(LAT - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!owner_q && bus.i_flush) begin
               kill_d = 1'b1;
            end
            if (cnt_q == '0) begin
               state_d = RESP;
               // A squashed fetch still finishes on the bus but must not overwrite i_rdata.
               if (owner_q && !wr_q) begin
                  d_rdata_d = bus.m_rdata;
               end else if (!owner_q && !kill_q && !bus.i_flush) begin
                  i_rdata_d = bus.m_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            kill_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.m_en    = (state_q == BUSY);
      bus.m_wr    = (state_q == BUSY) && wr_q;
      bus.m_addr  = addr_q;
      bus.m_wdata = wdata_q;
      bus.i_rdata = i_rdata_q;
      bus.d_rdata = d_rdata_q;
      bus.i_valid = rst_n && (state_q == RESP) && !owner_q && !kill_q && !bus.i_flush;
      bus.d_valid = rst_n && (state_q == RESP) && owner_q;
      bus.i_stall = rst_n && bus.i_req && !bus.i_valid;
      bus.d_stall = rst_n && bus.d_req && !bus.d_valid;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline.
- The memory has a fixed multi-cycle latency. The block sequences each access and holds address, control and write data stable for the whole access.
- It returns read data and a one-cycle valid to the owning requester, and generates the per-requester stall signals that freeze the pipeline.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- LAT, 4, memory cycles per access; minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- i_req  in  1  fetch read request; level, held until i_valid.
- i_addr  in  ADDR_W  fetch address.
- i_flush  in  1  squash in-flight fetch (taken branch).
- i_rdata  out  DATA_W  fetched instruction, registered.
- i_valid  out  1  one-cycle fetch completion.
- i_stall  out  1  fetch must hold.
- d_req  in  1  data request; level, held until d_valid.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- d_valid  out  1  one-cycle data completion (loads and stores).
- d_stall  out  1  MEM stage must hold.
- hlt  in  1  halt seen; blocks new fetch grants.
- m_en  out  1  memory enable.
- m_wr  out  1  memory write.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid in the last cycle of an access.

Behaviour:
- States: IDLE, BUSY, RESP. Registered owner bit: 0 = I, 1 = D.
- Latency counter width is clog2(LAT+1).
- Reset (rst_n=0 at a clk edge):
  - State returns to IDLE; counter, owner and kill flag are cleared.
  - All outputs are 0: m_en, m_wr, m_addr, m_wdata, i_rdata, d_rdata, i_valid, d_valid, i_stall, d_stall.
  - A reset mid-access abandons the access: m_en is low from the next cycle and no valid is issued.
- IDLE:
  - If d_req=1, grant D (fixed priority, data over fetch).
  - Otherwise, if i_req=1 and hlt=0, grant I.
  - On a grant: latch owner, addr, wr (forced 0 for I) and wdata (D only); load counter = LAT-1; go to BUSY.
  - Requests are sampled only in IDLE.
  - If hlt=1, i_req is ignored; d_req is still served.
- BUSY:
  - m_en=1; m_addr, m_wr and m_wdata come from the latches and are stable for exactly LAT consecutive cycles.
  - Counter decrements each cycle.
  - In the cycle with counter==0: capture m_rdata into the owner's rdata register (loads and fetches only; stores leave d_rdata unchanged); go to RESP.
- RESP:
  - m_en=0. Owner's valid=1 for exactly one cycle; next state IDLE.
  - Per access: grant edge = cycle 0; m_en high cycles 1..LAT; valid in cycle LAT+1; next grant no earlier than cycle LAT+2 (one bubble).
  - Back-to-back period is LAT+2 cycles.
- Flush:
  - i_flush=1 during BUSY with owner I, or in RESP with owner I, sets the kill flag.
  - The memory access always completes (not abortable).
  - i_valid = RESP & owner==I & ~kill & ~i_flush.
  - i_rdata is not updated when killed.
  - The kill flag clears on leaving RESP.
  - i_flush has no effect in IDLE or on D accesses.
- Stall:
  - i_stall = i_req & ~i_valid (combinational from the registered state).
  - d_stall = d_req & ~d_valid.
  - Both are 0 in reset.
- Simultaneous requests in IDLE: D wins. I is served on the next IDLE, LAT+2 cycles later.
- Dropped requests: deassertion of a request after its grant does not cancel the access; the completion pulse is still issued.
- i_rdata and d_rdata hold their last captured value between completions.
- LAT=1: BUSY lasts one cycle; valid in cycle 2.

Test Plan:
- LAT=4, d_req=0, i_req=1, i_addr=0x0010, memory[0x0010]=0xA1B2 at grant edge 0 -> m_en high cycles 1-4 with m_addr=0x0010, m_wr=0; i_valid=1 only in cycle 5 with i_rdata=0xA1B2; i_stall=1 cycles 0-4, 0 in cycle 5.
- i_req and d_req rise together; d_wr=1, d_addr=0x0200, d_wdata=0x1234 -> D granted first; m_wr=1 and m_wdata=0x1234 for 4 cycles; d_valid in cycle 5; I granted at edge 6 with i_valid in cycle 11; i_stall high cycles 0-10.
- Fetch grant, then i_flush=1 pulse in cycle 2 -> m_en still high cycles 1-4; i_valid stays 0 in cycle 5; i_rdata unchanged; next fetch completes normally with i_valid.
- hlt=1 with i_req=1 -> m_en never asserted; i_stall=1; a d_req load of 0x0300 (memory 0x5555) still completes with d_valid and d_rdata=0x5555.
- rst_n=0 in cycle 2 of a D store -> m_en=0 from cycle 3; no d_valid; all outputs 0; after release, a new i_req completes with full latency LAT+1.
- Continuous i_req with LAT=1 -> i_valid pulses every 3 cycles; m_en 1-cycle pulses.
